// File: rtl/gate_truth_checker_if.sv
// Bus between the gate-truth checker and the gate bank / its controller.
// Handshake: start is a level request that the checker samples only while
// idle (held high it simply re-launches after each run); done is a one-cycle
// pulse marking the end of a run, and the result fields (pass, err_count,
// fail_vec, fail_mask) are stable from that pulse until the next accepted
// start. There is no back-pressure: the checker never waits on its controller.
interface gate_truth_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             a_o;
    logic             b_o;
    logic [6:0]       gate_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       fail_vec;
    logic [6:0]       fail_mask;
    logic [1:0]       state_dbg;

    // Controller / gate-bank side: issues start, returns gate responses.
    modport master (
        output start,
        output gate_in,
        input  a_o,
        input  b_o,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec,
        input  fail_mask,
        input  state_dbg
    );

    // Checker side.
    modport slave (
        input  start,
        input  gate_in,
        output a_o,
        output b_o,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec,
        output fail_mask,
        output state_dbg
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Self-test engine for a two-input primitive gate bank. Walks {a,b} through
// 00,01,10,11 for NUM_PASSES sweeps, lets each vector settle for
// SETTLE_CYCLES clocks, samples the seven gate responses one cycle later and
// compares them with internally computed golden values. Reports pass/fail,
// a saturating error count and the first failing vector with its bit mask.
module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_truth_checker_if.slave  bus
);

    // Reject parameter values the counters cannot represent.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("gate_truth_checker: SETTLE_CYCLES must be in 1..15");
    end
    if (NUM_PASSES < 1 || NUM_PASSES > 255) begin : g_bad_passes
        $error("gate_truth_checker: NUM_PASSES must be in 1..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("gate_truth_checker: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [7:0]       LAST_PASS   = 8'(NUM_PASSES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX     = '1;

    state_t           state;
    logic [3:0]       settle_cnt;
    logic [7:0]       pass_cnt;
    logic [1:0]       vec;

    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] err_q;
    logic [1:0]       fail_vec_q;
    logic [6:0]       fail_mask_q;

    logic [6:0]       expected;
    logic [6:0]       mism;
    logic             mism_any;
    logic [CNT_W-1:0] err_next;
    logic             last_vec;
    logic [1:0]       vec_inc;

    // Golden response, packed {not_a, xnor, nor, nand, xor, or, and}.
    function automatic logic [6:0] golden(input logic [1:0] v);
        logic a;
        logic b;
        a = v[1];
        b = v[0];
        return {~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
    endfunction

    // Compare the current response against the golden value for vec and
    // precompute the saturated error count the SAMPLE state would commit.
    always_comb begin
        expected = golden(vec);
        mism     = bus.gate_in ^ expected;
        mism_any = |mism;
        err_next = err_q;
        if (mism_any && (err_q != ERR_MAX)) begin
            err_next = err_q + CNT_W'(1);
        end
        last_vec = (vec == 2'd3) && (pass_cnt == LAST_PASS);
        vec_inc  = vec + 2'd1;
    end

    // Sequencer: all outputs are registered here so they change only on
    // clock edges (or immediately on reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            settle_cnt  <= 4'd0;
            pass_cnt    <= 8'd0;
            vec         <= 2'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_vec_q  <= 2'd0;
            fail_mask_q <= 7'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_q       <= '0;
                        pass_q      <= 1'b0;
                        fail_vec_q  <= 2'd0;
                        fail_mask_q <= 7'd0;
                        vec         <= 2'd0;
                        a_q         <= 1'b0;
                        b_q         <= 1'b0;
                        settle_cnt  <= SETTLE_LOAD;
                        pass_cnt    <= 8'd0;
                        busy_q      <= 1'b1;
                        state       <= SETTLE;
                    end
                end

                SETTLE: begin
                    // gate_in is deliberately ignored until the count expires.
                    if (settle_cnt == 4'd1) begin
                        settle_cnt <= 4'd0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                SAMPLE: begin
                    err_q <= err_next;
                    // Only the first failing sample of a run is recorded.
                    if (mism_any && (err_q == '0)) begin
                        fail_vec_q  <= vec;
                        fail_mask_q <= mism;
                    end
                    if (last_vec) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_next == '0);
                        state  <= DONE;
                    end else begin
                        if (vec == 2'd3) begin
                            pass_cnt <= pass_cnt + 8'd1;
                        end
                        vec        <= vec_inc;
                        a_q        <= vec_inc[1];
                        b_q        <= vec_inc[0];
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end

                DONE: begin
                    // start is not looked at here; a held start relaunches
                    // from IDLE one cycle later.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Drive the bus from the registered state.
    assign bus.a_o       = a_q;
    assign bus.b_o       = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_vec_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.state_dbg = state;

endmodule
